// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin arbiter sharing one synchronous memory port
// between instruction fetch and load/store, with a saturating conflict counter.
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                ls_req,
  input  logic                ls_we,
  input  logic [ADDR_W-1:0]   ls_addr,
  input  logic [DATA_W-1:0]   ls_wdata,
  input  logic [DATA_W/8-1:0] ls_be,
  output logic                ls_gnt,
  output logic                ls_rvalid,
  output logic [DATA_W-1:0]   ls_rdata,
  output logic                mem_en,
  output logic                mem_wren,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic [CNT_W-1:0]    conflict_cnt
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IF_RESP = 2'd1,
    LS_RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                last_ls_q, last_ls_d;
  logic [DATA_W-1:0]   if_hold_q, if_hold_d;
  logic [DATA_W-1:0]   ls_hold_q, ls_hold_d;
  logic [CNT_W-1:0]    conflict_cnt_q, conflict_cnt_d;

  logic both_req;
  logic win_ls;

  assign both_req     = if_req & ls_req;
  assign win_ls       = both_req ? ~last_ls_q : ls_req;
  assign conflict_cnt = conflict_cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      last_ls_q      <= 1'b0;
      if_hold_q      <= '0;
      ls_hold_q      <= '0;
      conflict_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      last_ls_q      <= last_ls_d;
      if_hold_q      <= if_hold_d;
      ls_hold_q      <= ls_hold_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    last_ls_d      = last_ls_q;
    if_hold_d      = if_hold_q;
    ls_hold_d      = ls_hold_q;
    conflict_cnt_d = conflict_cnt_q;
    if_gnt         = 1'b0;
    ls_gnt         = 1'b0;
    if_rvalid      = 1'b0;
    ls_rvalid      = 1'b0;
    if_rdata       = if_hold_q;
    ls_rdata       = ls_hold_q;
    mem_en         = 1'b0;
    mem_wren       = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    mem_be         = '0;

    // Outputs are forced quiet while reset is held so an in-flight read is dropped.
    if (reset) begin
      if_rdata = '0;
      ls_rdata = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (if_req || ls_req) begin
            mem_en    = 1'b1;
            last_ls_d = win_ls;
            if (both_req && (conflict_cnt_q != {CNT_W{1'b1}})) begin
              conflict_cnt_d = conflict_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (win_ls) begin
              ls_gnt   = 1'b1;
              mem_addr = ls_addr;
              if (ls_we) begin
                mem_wren  = 1'b1;
                mem_wdata = ls_wdata;
                mem_be    = ls_be;
              end else begin
                state_d = LS_RESP;
              end
            end else begin
              if_gnt   = 1'b1;
              mem_addr = if_addr;
              state_d  = IF_RESP;
            end
          end
        end
        IF_RESP: begin
          if_rvalid = 1'b1;
          if_rdata  = mem_rdata;
          if_hold_d = mem_rdata;
          state_d   = IDLE;
        end
        LS_RESP: begin
          ls_rvalid = 1'b1;
          ls_rdata  = mem_rdata;
          ls_hold_d = mem_rdata;
          state_d   = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the single synchronous memory port between the core's instruction-fetch path and its load/store path. Arbitration between the two requesters is round-robin. The block issues at most one memory access per grant, returns read data one cycle after the grant, and keeps a saturating count of arbitration conflicts for debug. It sits between the multi-cycle RISC-V core and the unified instruction/data memory.

## Interface
Parameters:
- ADDR_W, 32, address width for both requesters and the memory.
- DATA_W, 32, data width; DATA_W/8 byte enables.
- CNT_W, 16, width of the conflict counter.

Ports (reset: reset, synchronous, active-high; clock: clk):
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high.
- if_req  in  1  fetch read request; held high until if_gnt.
- if_addr  in  ADDR_W  fetch address; stable while if_req is high.
- if_gnt  out  1  fetch request accepted this cycle.
- if_rvalid  out  1  fetch data valid; one cycle pulse.
- if_rdata  out  DATA_W  fetch data; holds the last returned word.
- ls_req  in  1  load/store request; held high until ls_gnt.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_be  in  DATA_W/8  store byte enables.
- ls_gnt  out  1  load/store request accepted this cycle.
- ls_rvalid  out  1  load data valid; one cycle pulse; never asserted for stores.
- ls_rdata  out  DATA_W  load data; holds the last returned word.
- mem_en  out  1  memory access this cycle.
- mem_wren  out  1  write strobe.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_be  out  DATA_W/8  memory byte enables.
- mem_rdata  in  DATA_W  memory read data; valid the cycle after a read with mem_en=1.
- conflict_cnt  out  CNT_W  number of cycles in which both requests were high and one was granted; saturating.

## Operation
State machine states: IDLE, IF_RESP, LS_RESP.

IDLE:
- Winner selection:
  - Only one req high: that requester wins.
  - Both high: the requester that is not last_winner wins.
  - Neither high: no grant; mem_* outputs are all 0.
- The winner's gnt is asserted combinationally in the same cycle. mem_en=1 and mem_addr = the winner's address.
- IF grant: mem_wren=0, mem_be=0, mem_wdata=0; next state IF_RESP.
- LS grant with ls_we=1: mem_wren=1, mem_wdata=ls_wdata, mem_be=ls_be; stay in IDLE. A store completes on its grant.
- LS grant with ls_we=0: mem_wren=0; next state LS_RESP.
- last_winner <= winner on every grant.
- conflict_cnt increments when both reqs are high in IDLE; it saturates at all-ones.

IF_RESP / LS_RESP:
- No grants are issued and all mem_* outputs are 0.
- The corresponding rvalid is 1 and rdata = mem_rdata. The rdata hold register captures mem_rdata.
- Next state: IDLE.

rdata outputs:
- Outside the response cycle, if_rdata and ls_rdata show their hold registers.
- The other requester's hold register is unchanged by a response.

Reset values:
- State IDLE; last_winner = IF, so LS wins the first conflict.
- All gnt/rvalid/mem_* outputs 0; both rdata hold registers 0; conflict_cnt 0.
- Reset asserted mid-read abandons the access: no rvalid is issued and the hold registers clear.

## Timing
- Read: grant at cycle T, rvalid and data at T+1. The earliest next grant is T+2, so sustained reads run at one per 2 cycles.
- Store: grant at T, write at T. A next grant is possible at T+1, so back-to-back stores run at one per cycle.
- Request changes in a response cycle are ignored; a held request is arbitrated at the next IDLE cycle.
- Simultaneous requests, alternating: with both held high, grants alternate LS, IF, LS, IF...
- Outputs gnt and mem_* are combinational from IDLE state and the requests. rvalid is decoded from the state register.

## Test plan
- **Reset:** drive reset for 2 cycles with both reqs high -> all outputs 0, conflict_cnt=0. The first post-reset cycle grants LS.
- **Single fetch:** if_req with if_addr=0x00000010, mem_rdata=0x00500093 at T+1 -> if_gnt at T, mem_addr=0x10, if_rvalid at T+1, if_rdata=0x00500093 held afterwards.
- **Back-to-back stores:** ls_we=1 to addr 0x100 then 0x104, ls_be=4'b1111, wdata 0xDEADBEEF / 0x12345678 -> mem_wren in two consecutive cycles with the matching addr/data; ls_rvalid stays 0.
- **Conflict alternation:** if_req and ls_req (load) held high for 8 cycles -> grant order LS, IF, LS, IF on cycles 0, 2, 4, 6; conflict_cnt=4.
- **Reset mid-read:** IF grant at T, reset at T+1 -> no if_rvalid, if_rdata=0, state IDLE at T+2.
- **Saturation:** with CNT_W=4, apply 20 conflict cycles -> conflict_cnt stops at 15.
